// File: rtl/alignment.sv
// ---------------------------------------------------------------------------
// alignment
//   Serial-to-parallel code-group aligner for a 10b line code. Recovered bits
//   are shifted into a 10-bit window; a comma (0011111 / 1100000 in the first
//   seven bits of the window) establishes the code-group boundary. While
//   aligned, one code-group is emitted every 10 bits. A comma seen off the
//   current boundary realigns when ENABLE_CDET is high.
//
// Ports
//   CLK           in   rising-edge clock, one serial bit per cycle
//   RESET         in   asynchronous, active-high
//   RX_BIT        in   recovered serial bit
//   SIGNAL_DETECT in   PMD signal present (low drops alignment)
//   ENABLE_CDET   in   permit comma-based (re)alignment
//   PUDI          out  aligned code-group, PUDI[9] = first bit received (a)
//   PUDI_VALID    out  one-cycle pulse when PUDI updates
//   COMMA_FOUND   out  pulses with PUDI_VALID when the code-group is a comma
//   ALIGNED       out  code-group boundary established
//   REALIGN_CNT   out  realignment event count, saturating at 15
// ---------------------------------------------------------------------------
module alignment (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX_BIT,
  input  logic       SIGNAL_DETECT,
  input  logic       ENABLE_CDET,
  output logic [9:0] PUDI,
  output logic       PUDI_VALID,
  output logic       COMMA_FOUND,
  output logic       ALIGNED,
  output logic [3:0] REALIGN_CNT
);

  localparam int DATA_W = 10;

  typedef enum logic {
    ST_UNALIGNED = 1'b0,
    ST_ALIGNED   = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   sr_p0;
  logic [3:0]          fill_p0;
  logic [3:0]          bc_p0;
  logic                comma_det;
  logic                emit;
  logic                comma_out;
  logic                realign;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

  // Only trust the window once it holds ten real bits since the last restart.
  assign comma_det = (fill_p0 == 4'd10) &&
                     ((sr_p0[9:3] == 7'b0011111) || (sr_p0[9:3] == 7'b1100000));

  assign ALIGNED = (state == ST_ALIGNED);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_UNALIGNED;
    end else begin
      state <= state_nxt;
    end
  end

  // Loss of signal outranks every comma event in the same cycle.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    comma_out = 1'b0;
    realign   = 1'b0;
    if (!SIGNAL_DETECT) begin
      state_nxt = ST_UNALIGNED;
    end else begin
      case (state)
        ST_UNALIGNED: begin
          if (comma_det && ENABLE_CDET) begin
            emit      = 1'b1;
            comma_out = 1'b1;
            realign   = 1'b1;
            state_nxt = ST_ALIGNED;
          end
        end
        ST_ALIGNED: begin
          if (bc_p0 == 4'd9) begin
            // On-boundary comma is a normal emission, not a realignment.
            emit      = 1'b1;
            comma_out = comma_det;
          end else if (comma_det && ENABLE_CDET) begin
            emit      = 1'b1;
            comma_out = 1'b1;
            realign   = 1'b1;
          end
        end
        default: state_nxt = ST_UNALIGNED;
      endcase
    end
  end

  // ---- stage p0: serial window, fill and bit counters ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sr_p0   <= '0;
      fill_p0 <= '0;
      bc_p0   <= '0;
    end else begin
      sr_p0 <= {sr_p0[DATA_W-2:0], RX_BIT};
      if (!SIGNAL_DETECT) begin
        fill_p0 <= '0;
        bc_p0   <= '0;
      end else begin
        fill_p0 <= sat_inc(fill_p0, 4'd10);
        if (emit || (state != ST_ALIGNED)) begin
          bc_p0 <= '0;
        end else begin
          bc_p0 <= bc_p0 + 4'd1;
        end
      end
    end
  end

  // ---- stage p1: parallel output register ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PUDI        <= '0;
      PUDI_VALID  <= 1'b0;
      COMMA_FOUND <= 1'b0;
      REALIGN_CNT <= '0;
    end else begin
      PUDI_VALID  <= emit;
      COMMA_FOUND <= comma_out;
      if (emit) begin
        PUDI <= sr_p0;
      end
      if (realign) begin
        REALIGN_CNT <= sat_inc(REALIGN_CNT, 4'd15);
      end
    end
  end

endmodule
